// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads and stores on the data-memory bus and registers the MEM/WB outputs.
// Optional MEM_TIMEOUT_EN: bounds the wait for dmem_ack to TIMEOUT_CYCLES and drives bus_err.
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        valid_in,
   input  logic        zero_in,
   input  logic        branch_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic        reg_read_in,
   input  logic        mem_to_reg_in,
   input  logic [31:0] aluoutput_in,
   input  logic [31:0] b_in,
   input  logic [31:0] npc_in,
   input  logic [4:0]  rd_in,
   output logic        stall_out,
   output logic        branch_taken_out,
   output logic [31:0] branch_target_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        valid_out,
   output logic        reg_write_out,
   output logic        mem_to_reg_out,
   output logic [31:0] lmd_out,
   output logic [31:0] aluoutput_out,
   output logic [4:0]  rd_out,
   output logic        misalign_err,
   output logic        bus_err
);

   typedef enum logic [0:0] {StIdle, StAccess} state_e;

   state_e state_q, state_d;

   logic        mem_op, aligned, start_access, misaligned_op, timeout;

   // Access context latched at acceptance so the bus stays stable while stalled
   logic [31:0] addr_q, wdata_q;
   logic        we_q, acc_rw_q, acc_m2r_q;
   logic [4:0]  acc_rd_q;

   logic        wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d, wb_m2r_q, wb_m2r_d;
   logic [31:0] wb_lmd_q, wb_lmd_d, wb_alu_q, wb_alu_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic        misalign_q, misalign_d;

   logic        unused_npc;

   assign unused_npc    = ^npc_in;
   assign mem_op        = mem_read_in | mem_write_in;
   assign aligned       = (aluoutput_in[1:0] == 2'b00);
   assign start_access  = valid_in & mem_op & aligned;
   assign misaligned_op = valid_in & mem_op & ~aligned;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] cnt_q;
   logic            bus_err_q;

   assign timeout = (state_q == StAccess) & ~dmem_ack & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         // Held at zero in IDLE, so every ACCESS entry starts counting from zero
         if (state_q == StIdle) cnt_q <= '0;
         else                   cnt_q <= cnt_q + 1'b1;
         if (timeout) bus_err_q <= 1'b1;
      end
   end

   assign bus_err = bus_err_q;
`else
   logic unused_timeout_cycles;

   assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
   assign timeout               = 1'b0;
   assign bus_err               = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= StIdle;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start_access) state_d = StAccess;
         StAccess: if (dmem_ack || timeout) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      dmem_req         = 1'b0;
      dmem_we          = 1'b0;
      stall_out        = 1'b0;
      branch_taken_out = 1'b0;
      unique case (state_q)
         StIdle: begin
            stall_out        = start_access;
            branch_taken_out = valid_in & branch_in & zero_in;
         end
         StAccess: begin
            dmem_req  = 1'b1;
            dmem_we   = we_q;
            // Release upstream on timeout too, otherwise it would replay the failed access
            stall_out = ~(dmem_ack | timeout);
         end
         default: ;
      endcase
   end

   assign branch_target_out = aluoutput_in;
   assign dmem_addr         = addr_q;
   assign dmem_wdata        = wdata_q;

   always_comb begin
      wb_valid_d = wb_valid_q;
      wb_rw_d    = wb_rw_q;
      wb_m2r_d   = wb_m2r_q;
      wb_lmd_d   = wb_lmd_q;
      wb_alu_d   = wb_alu_q;
      wb_rd_d    = wb_rd_q;
      misalign_d = misalign_q | (state_q == StIdle && misaligned_op);
      unique case (state_q)
         StIdle: begin
            wb_valid_d = valid_in & ~start_access;
            wb_rw_d    = 1'b0;
            if (valid_in && !start_access) begin
               wb_rw_d  = reg_read_in & ~misaligned_op;
               wb_m2r_d = mem_to_reg_in;
               wb_lmd_d = '0;
               wb_alu_d = aluoutput_in;
               wb_rd_d  = rd_in;
            end
         end
         StAccess: begin
            wb_valid_d = 1'b0;
            if (dmem_ack) begin
               wb_valid_d = 1'b1;
               wb_rw_d    = acc_rw_q;
               wb_m2r_d   = acc_m2r_q;
               wb_lmd_d   = we_q ? 32'h0 : dmem_rdata;
               wb_alu_d   = addr_q;
               wb_rd_d    = acc_rd_q;
            end else if (timeout) begin
               wb_valid_d = 1'b1;
               wb_rw_d    = 1'b0;
               wb_m2r_d   = 1'b0;
               wb_lmd_d   = '0;
               wb_alu_d   = addr_q;
               wb_rd_d    = acc_rd_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_valid_q <= 1'b0;
         wb_rw_q    <= 1'b0;
         wb_m2r_q   <= 1'b0;
         wb_lmd_q   <= '0;
         wb_alu_q   <= '0;
         wb_rd_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         wb_valid_q <= wb_valid_d;
         wb_rw_q    <= wb_rw_d;
         wb_m2r_q   <= wb_m2r_d;
         wb_lmd_q   <= wb_lmd_d;
         wb_alu_q   <= wb_alu_d;
         wb_rd_q    <= wb_rd_d;
         misalign_q <= misalign_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         acc_rw_q  <= 1'b0;
         acc_m2r_q <= 1'b0;
         acc_rd_q  <= '0;
      end else if (state_q == StIdle && start_access) begin
         addr_q    <= aluoutput_in;
         wdata_q   <= b_in;
         we_q      <= mem_write_in;
         acc_rw_q  <= reg_read_in;
         acc_m2r_q <= mem_to_reg_in;
         acc_rd_q  <= rd_in;
      end
   end

   assign valid_out      = wb_valid_q;
   assign reg_write_out  = wb_rw_q;
   assign mem_to_reg_out = wb_m2r_q;
   assign lmd_out        = wb_lmd_q;
   assign aluoutput_out  = wb_alu_q;
   assign rd_out         = wb_rd_q;
   assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; MEM/WB results are checked against a scoreboard queue.
// Define MEM_TIMEOUT_EN to also exercise the ack timeout (DUT built with TIMEOUT_CYCLES=4).
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        valid_in, zero_in, branch_in, mem_read_in, mem_write_in, reg_read_in;
   logic        mem_to_reg_in;
   logic [31:0] aluoutput_in, b_in, npc_in;
   logic [4:0]  rd_in;
   logic        stall_out, branch_taken_out;
   logic [31:0] branch_target_out;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ack;
   logic        valid_out, reg_write_out, mem_to_reg_out;
   logic [31:0] lmd_out, aluoutput_out;
   logic [4:0]  rd_out;
   logic        misalign_err, bus_err;

   typedef struct packed {
      logic        rw;
      logic        m2r;
      logic [31:0] lmd;
      logic [31:0] alu;
      logic [4:0]  rd;
   } wb_t;

   wb_t exp_q[$];
   int  errors = 0;
   int  checks = 0;
   int  cnt;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .valid_in         (valid_in),
      .zero_in          (zero_in),
      .branch_in        (branch_in),
      .mem_read_in      (mem_read_in),
      .mem_write_in     (mem_write_in),
      .reg_read_in      (reg_read_in),
      .mem_to_reg_in    (mem_to_reg_in),
      .aluoutput_in     (aluoutput_in),
      .b_in             (b_in),
      .npc_in           (npc_in),
      .rd_in            (rd_in),
      .stall_out        (stall_out),
      .branch_taken_out (branch_taken_out),
      .branch_target_out(branch_target_out),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_wdata       (dmem_wdata),
      .dmem_rdata       (dmem_rdata),
      .dmem_ack         (dmem_ack),
      .valid_out        (valid_out),
      .reg_write_out    (reg_write_out),
      .mem_to_reg_out   (mem_to_reg_out),
      .lmd_out          (lmd_out),
      .aluoutput_out    (aluoutput_out),
      .rd_out           (rd_out),
      .misalign_err     (misalign_err),
      .bus_err          (bus_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_idle();
      valid_in      = 1'b0;
      zero_in       = 1'b0;
      branch_in     = 1'b0;
      mem_read_in   = 1'b0;
      mem_write_in  = 1'b0;
      reg_read_in   = 1'b0;
      mem_to_reg_in = 1'b0;
      aluoutput_in  = '0;
      b_in          = '0;
      npc_in        = '0;
      rd_in         = '0;
   endtask

   // Advance one clock and retire any MEM/WB write against the scoreboard
   task automatic step();
      wb_t e;
      @(posedge clk);
      #1;
      if (valid_out) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_wb", 32'(valid_out), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wb_reg_write", 32'(reg_write_out), 32'(e.rw));
            chk("wb_mem_to_reg", 32'(mem_to_reg_out), 32'(e.m2r));
            chk("wb_lmd", lmd_out, e.lmd);
            chk("wb_alu", aluoutput_out, e.alu);
            chk("wb_rd", 32'(rd_out), 32'(e.rd));
         end
      end
   endtask

   task automatic drive_load(input logic [31:0] addr, input logic [4:0] rd);
      set_idle();
      valid_in      = 1'b1;
      mem_read_in   = 1'b1;
      mem_to_reg_in = 1'b1;
      reg_read_in   = 1'b1;
      aluoutput_in  = addr;
      rd_in         = rd;
   endtask

   initial begin
      reset_n    = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      set_idle();
      #3;
      chk("rst_valid", 32'(valid_out), 0);
      chk("rst_req", 32'(dmem_req), 0);
      chk("rst_lmd", lmd_out, 0);
      chk("rst_misalign", 32'(misalign_err), 0);
      chk("rst_bus_err", 32'(bus_err), 0);
      #9 reset_n = 1'b1;
      step();

      // ALU op: one-cycle pass-through
      valid_in = 1'b1; reg_read_in = 1'b1; aluoutput_in = 32'h0000_1234; rd_in = 5'd5;
      #1 chk("alu_stall", 32'(stall_out), 0);
      exp_q.push_back('{rw: 1'b1, m2r: 1'b0, lmd: 32'h0, alu: 32'h1234, rd: 5'd5});
      step();
      chk("alu_valid", 32'(valid_out), 1);
      set_idle();
      step();
      chk("bubble_valid", 32'(valid_out), 0);
      chk("bubble_reg_write", 32'(reg_write_out), 0);

      // Branch resolution is combinational and only in IDLE
      valid_in = 1'b1; branch_in = 1'b1; zero_in = 1'b1; aluoutput_in = 32'h400;
      #1 chk("br_taken", 32'(branch_taken_out), 1);
      chk("br_target", branch_target_out, 32'h400);
      zero_in = 1'b0;
      #1 chk("br_not_taken", 32'(branch_taken_out), 0);
      exp_q.push_back('{rw: 1'b0, m2r: 1'b0, lmd: 32'h0, alu: 32'h400, rd: 5'd0});
      step();
      set_idle();

      // Load at 0x100, ack in the second ACCESS cycle
      drive_load(32'h100, 5'd7);
      cnt = 0;
      #1 cnt += int'(stall_out);
      chk("ld_req_idle", 32'(dmem_req), 0);
      exp_q.push_back('{rw: 1'b1, m2r: 1'b1, lmd: 32'hCAFE_F00D, alu: 32'h100, rd: 5'd7});
      step();
      cnt += int'(stall_out);
      chk("ld_req", 32'(dmem_req), 1);
      chk("ld_addr", dmem_addr, 32'h100);
      chk("ld_we", 32'(dmem_we), 0);
      chk("ld_bubble", 32'(valid_out), 0);
      step();
      chk("ld_req_held", 32'(dmem_req), 1);
      dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
      #1 cnt += int'(stall_out);
      chk("ld_stall_cycles", 32'(cnt), 2);
      step();
      chk("ld_valid", 32'(valid_out), 1);
      chk("ld_req_drop", 32'(dmem_req), 0);
      set_idle();
      dmem_rdata = 32'h1111_2222;
      step();
      chk("idle_ack_ignored", 32'(valid_out), 0);
      dmem_ack = 1'b0;

      // Aligned store; bus data must stay latched even if b_in moves
      set_idle();
      valid_in = 1'b1; mem_write_in = 1'b1; aluoutput_in = 32'h200; b_in = 32'hDEAD_BEEF;
      exp_q.push_back('{rw: 1'b0, m2r: 1'b0, lmd: 32'h0, alu: 32'h200, rd: 5'd0});
      step();
      b_in = 32'h0BAD_0BAD;
      #1 chk("st_we", 32'(dmem_we), 1);
      chk("st_wdata", dmem_wdata, 32'hDEAD_BEEF);
      chk("st_addr", dmem_addr, 32'h200);
      dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
      step();
      chk("st_valid", 32'(valid_out), 1);
      dmem_ack = 1'b0;
      set_idle();

      // Misaligned store: no bus activity, sticky error
      valid_in = 1'b1; mem_write_in = 1'b1; reg_read_in = 1'b1; aluoutput_in = 32'h103;
      rd_in = 5'd3;
      #1 chk("mis_stall", 32'(stall_out), 0);
      chk("mis_req_comb", 32'(dmem_req), 0);
      exp_q.push_back('{rw: 1'b0, m2r: 1'b0, lmd: 32'h0, alu: 32'h103, rd: 5'd3});
      step();
      chk("mis_err", 32'(misalign_err), 1);
      chk("mis_req", 32'(dmem_req), 0);
      chk("mis_reg_write", 32'(reg_write_out), 0);
      set_idle();
      step();
      chk("mis_sticky", 32'(misalign_err), 1);
      chk("no_bus_err", 32'(bus_err), 0);

      // Reset in the middle of an access abandons it
      drive_load(32'h300, 5'd9);
      step();
      chk("rst_acc_req", 32'(dmem_req), 1);
      #2 reset_n = 1'b0;
      set_idle();
      #1 chk("rst_acc_req_drop", 32'(dmem_req), 0);
      chk("rst_acc_valid", 32'(valid_out), 0);
      chk("rst_acc_alu", aluoutput_out, 0);
      chk("rst_acc_misalign", 32'(misalign_err), 0);
      chk("rst_acc_stall", 32'(stall_out), 0);
      #2 reset_n = 1'b1;
      dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
      step();
      chk("rst_spurious_ack", 32'(valid_out), 0);
      dmem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
      // No ack: request held four cycles, then error write-back
      drive_load(32'h40, 5'd4);
      exp_q.push_back('{rw: 1'b0, m2r: 1'b0, lmd: 32'h0, alu: 32'h40, rd: 5'd4});
      step();
      cnt = 0;
      while (dmem_req && cnt < 10) begin
         cnt++;
         if (!dmem_req) break;
         step();
      end
      chk("to_req_cycles", 32'(cnt), 4);
      chk("to_bus_err", 32'(bus_err), 1);
      chk("to_valid", 32'(valid_out), 1);
      set_idle();
      #2 reset_n = 1'b0;
      #2 reset_n = 1'b1;
      // Ack in the terminal cycle wins over the timeout
      drive_load(32'h44, 5'd6);
      exp_q.push_back('{rw: 1'b1, m2r: 1'b1, lmd: 32'h1234_5678, alu: 32'h44, rd: 5'd6});
      step();
      step();
      step();
      step();
      chk("to_ack_req", 32'(dmem_req), 1);
      dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
      step();
      chk("to_ack_valid", 32'(valid_out), 1);
      chk("to_ack_bus_err", 32'(bus_err), 0);
      dmem_ack = 1'b0;
      set_idle();
`endif

      step();
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum wait cycles for dmem_ack; used only when MEM_TIMEOUT_EN is defined.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 valid_in  in  1  EX/MEM register holds a live instruction.
REQ-005 zero_in, branch_in, mem_read_in, mem_write_in, reg_read_in, mem_to_reg_in  in  1 each  EX/MEM control (reg_read_in = register write-back enable).
REQ-006 aluoutput_in  in  32  ALU result or effective address; b_in  in  32  store data; npc_in  in  32  PC+4; rd_in  in  5  destination register.
REQ-007 stall_out  out  1  upstream must hold EX/MEM contents and stop advancing.
REQ-008 branch_taken_out  out  1; branch_target_out  out  32  branch redirect to fetch.
REQ-009 dmem_req, dmem_we  out  1; dmem_addr, dmem_wdata  out  32; dmem_rdata  in  32; dmem_ack  in  1  data-memory bus.
REQ-010 valid_out, reg_write_out, mem_to_reg_out  out  1; lmd_out, aluoutput_out  out  32; rd_out  out  5  registered MEM/WB outputs.
REQ-011 misalign_err, bus_err  out  1  sticky error flags.

Function
REQ-012 FSM states are IDLE and ACCESS.
REQ-013 IDLE, valid_in and no memory op: capture aluoutput/rd/controls into MEM/WB on the next edge with valid_out=1 and lmd_out=0 (1-cycle latency); stall_out=0.
REQ-014 IDLE, valid_in and (mem_read_in or mem_write_in) with aluoutput_in[1:0]==0: stall_out=1 combinationally; latch address, b_in, and we=mem_write_in into internal registers; go to ACCESS; write valid_out=0 (bubble).
REQ-015 ACCESS: dmem_req=1, with dmem_addr, dmem_wdata, and dmem_we held stable from the latched values; stall_out = ~dmem_ack.
REQ-016 ACCESS with dmem_ack: capture dmem_rdata into lmd_out for reads (0 for writes) and write MEM/WB with valid_out=1; return to IDLE. Minimum load/store latency is 2 cycles from acceptance to valid_out.
REQ-017 Memory op with aluoutput_in[1:0]!=0: no bus request; set misalign_err; write MEM/WB with valid_out=1 and reg_write_out=0; stall_out=0.
REQ-018 branch_taken_out = valid_in & branch_in & zero_in & (state==IDLE); branch_target_out = aluoutput_in (combinational).
REQ-019 valid_in=0 in IDLE: write valid_out=0 and reg_write_out=0 on the next edge.
REQ-020 Ignore dmem_ack while in IDLE.
REQ-021 dmem_req=0 and dmem_we=0 whenever the state is not ACCESS.
REQ-022 Never drop dmem_req in ACCESS before dmem_ack, except on timeout (REQ-027).

Reset
REQ-023 reset_n low immediately sets state=IDLE and clears all MEM/WB outputs, misalign_err, bus_err, latched address/data, and the timeout counter.
REQ-024 Reset during ACCESS deasserts dmem_req asynchronously; the pending access is abandoned and no MEM/WB write occurs.
REQ-025 Sticky error flags clear only on reset.

Configuration
REQ-026 Macro MEM_TIMEOUT_EN defined: an internal counter counts ACCESS cycles, clears on entry to ACCESS, and has width clog2(TIMEOUT_CYCLES+1).
REQ-027 With MEM_TIMEOUT_EN, if TIMEOUT_CYCLES cycles elapse in ACCESS without dmem_ack: return to IDLE, set bus_err, write MEM/WB with valid_out=1, reg_write_out=0, lmd_out=0. If dmem_ack arrives in the terminal cycle, ack wins.
REQ-028 Without MEM_TIMEOUT_EN: no counter logic; ACCESS waits indefinitely; bus_err tied to 0.

Verification
REQ-029 ALU op (aluoutput_in=0x0000_1234, rd_in=5, reg_read_in=1) -> next cycle valid_out=1, aluoutput_out=0x1234, rd_out=5, stall_out=0.
REQ-030 Load at 0x100, dmem_ack two cycles after request with rdata=0xCAFE_F00D -> stall_out high 2 cycles, lmd_out=0xCAFEF00D, mem_to_reg_out=1, valid_out=1.
REQ-031 Store at 0x0000_0103 -> dmem_req never rises, misalign_err=1, reg_write_out=0.
REQ-032 Branch with zero_in=1, aluoutput_in=0x400 -> same-cycle branch_taken_out=1, branch_target_out=0x400; with zero_in=0 -> branch_taken_out=0.
REQ-033 reset_n low during ACCESS -> dmem_req=0 before the next clock edge, all outputs 0; spurious ack after reset -> no valid_out.
REQ-034 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> dmem_req drops after 4 ACCESS cycles, bus_err=1, valid_out=1, reg_write_out=0; ack in the 4th cycle -> normal completion, bus_err=0.
